handshake_arbiter: RTL

HANDSHAKE_ARBITER -- requirements
Module: handshake_arbiter

---
 rtl/handshake_arbiter_pkg.sv | 16 +
 rtl/handshake_arbiter_sync_ff.sv | 26 ++
 rtl/handshake_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/handshake_arbiter_pkg.sv
// Shared definitions for the 4-phase handshake arbiter: FSM states and default sizing.
package handshake_arbiter_pkg;

    localparam int N_DEFAULT           = 4;
    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int TIMEOUT_DEFAULT     = 255;
    localparam int WAIT_CNT_W          = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_HOLD = 2'd2,
        ST_RTZ  = 2'd3
    } state_t;

endpackage

// File: rtl/handshake_arbiter_sync_ff.sv
// Multi-flop synchronizer for asynchronous level inputs; clears to zero on reset.
module sync_ff
    import handshake_arbiter_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= {stage_reg[STAGES-2:0], d};
        end
    end

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/handshake_arbiter.sv
// Round-robin arbiter forwarding N 4-phase requesters onto one shared 4-phase pipeline stage.
module handshake_arbiter
    import handshake_arbiter_pkg::*;
#(
    parameter int N           = N_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int TIMEOUT     = TIMEOUT_DEFAULT,
    localparam int ID_W       = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    request,
    output logic [N-1:0]    ack,
    output logic            next_request,
    input  logic            next_ack,
    output logic [ID_W-1:0] grant_id,
    output logic            busy,
    output logic            timeout_err
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(TIMEOUT);
    localparam logic [ID_W-1:0]       LAST_ID     = ID_W'(N - 1);
    localparam logic [ID_W:0]         N_WIDE      = (ID_W + 1)'(N);
    localparam logic [N-1:0]          ACK_LSB     = N'(1);

    logic [N-1:0]            req_sync;
    logic                    next_ack_sync;

    state_t                  state_reg;
    logic [ID_W-1:0]         grant_reg;
    logic [ID_W-1:0]         rr_ptr_reg;
    logic [N-1:0]            ack_reg;
    logic                    next_request_reg;
    logic                    busy_reg;
    logic                    timeout_err_reg;
    logic [WAIT_CNT_W-1:0]   wait_cnt_reg;

    logic                    pick_valid;
    logic [ID_W-1:0]         pick_idx;
    logic [ID_W:0]           rot_sum;
    logic [ID_W-1:0]         rot_idx;
    logic [WAIT_CNT_W-1:0]   wait_cnt_next;
    logic                    wait_hit;
    logic [ID_W-1:0]         rr_ptr_next;

    sync_ff #(.WIDTH(N), .STAGES(SYNC_STAGES)) u_req_sync (
        .clk   (clk),
        .reset (reset),
        .d     (request),
        .q     (req_sync)
    );

    sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d     (next_ack),
        .q     (next_ack_sync)
    );

    // Scan downward from the farthest offset so the nearest set bit at/after rr_ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        rot_sum    = '0;
        rot_idx    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            rot_sum = {1'b0, rr_ptr_reg} + (ID_W + 1)'(k);
            if (rot_sum >= N_WIDE) begin
                rot_sum = rot_sum - N_WIDE;
            end
            rot_idx = rot_sum[ID_W-1:0];
            if (req_sync[rot_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = rot_idx;
            end
        end
    end

    // Counter saturates at TIMEOUT so a long stall can never wrap back below the limit.
    always_comb begin
        wait_cnt_next = (wait_cnt_reg == TIMEOUT_CNT) ? wait_cnt_reg : wait_cnt_reg + 1'b1;
        wait_hit      = (wait_cnt_next == TIMEOUT_CNT);
        rr_ptr_next   = (grant_reg == LAST_ID) ? '0 : grant_reg + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= ST_IDLE;
            grant_reg        <= '0;
            rr_ptr_reg       <= '0;
            ack_reg          <= '0;
            next_request_reg <= 1'b0;
            busy_reg         <= 1'b0;
            timeout_err_reg  <= 1'b0;
            wait_cnt_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_reg        <= ST_FWD;
                        grant_reg        <= pick_idx;
                        next_request_reg <= 1'b1;
                        busy_reg         <= 1'b1;
                        wait_cnt_reg     <= '0;
                    end
                end
                ST_FWD: begin
                    if (next_ack_sync) begin
                        state_reg    <= ST_HOLD;
                        ack_reg      <= ACK_LSB << grant_reg;
                        wait_cnt_reg <= '0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_next;
                        if (wait_hit) begin
                            timeout_err_reg <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!req_sync[grant_reg]) begin
                        state_reg        <= ST_RTZ;
                        next_request_reg <= 1'b0;
                        wait_cnt_reg     <= '0;
                    end
                end
                ST_RTZ: begin
                    if (!next_ack_sync) begin
                        state_reg    <= ST_IDLE;
                        ack_reg      <= '0;
                        rr_ptr_reg   <= rr_ptr_next;
                        busy_reg     <= 1'b0;
                        wait_cnt_reg <= '0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_next;
                        if (wait_hit) begin
                            timeout_err_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg        <= ST_IDLE;
                    ack_reg          <= '0;
                    next_request_reg <= 1'b0;
                    busy_reg         <= 1'b0;
                    wait_cnt_reg     <= '0;
                end
            endcase
        end
    end

    assign ack          = ack_reg;
    assign next_request = next_request_reg;
    assign grant_id     = grant_reg;
    assign busy         = busy_reg;
    assign timeout_err  = timeout_err_reg;

endmodule
